// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter feeding a shared 3-stage signed multiplier.
// Each result is strobed back to the requester that issued the operation.
// Optional build macro MUL_ARBITER_SAT_EN: saturate the product to DATA_W
// signed range instead of wrapping. The default build truncates.
module mul_arbiter #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_in0,
  input  logic [N_REQ*DATA_W-1:0]   req_in1,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          res_valid,
  output logic [DATA_W-1:0]         res_data,
  output logic                      busy,
  output logic [31:0]               issue_cnt
);

  localparam int TAG_W = $clog2(N_REQ);
  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(N_REQ - 1);

  // Per-requester operand views of the flat input buses
  logic [DATA_W-1:0] op_a [N_REQ];
  logic [DATA_W-1:0] op_b [N_REQ];

  // Arbitration state
  logic [TAG_W-1:0]  ptr_reg;
  logic [TAG_W-1:0]  grant_idx;
  logic [TAG_W-1:0]  cand;
  logic              grant_found;
  logic              accept;
  logic [31:0]       issue_cnt_reg;

  // Pipeline stages
  logic              s1_valid, s2_valid, s3_valid;
  logic [TAG_W-1:0]  s1_tag, s2_tag, s3_tag;
  logic [DATA_W-1:0] s1_a, s1_b;
  logic [2*DATA_W-1:0] s2_prod;
  logic [2*DATA_W-1:0] ext_a, ext_b;
  logic [DATA_W-1:0] fmt_res;
  logic [DATA_W-1:0] res_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign op_a[gi]      = req_in0[gi*DATA_W +: DATA_W];
      assign op_b[gi]      = req_in1[gi*DATA_W +: DATA_W];
      assign req_ready[gi] = grant_found && (grant_idx == TAG_W'(gi));
      assign res_valid[gi] = s3_valid && (s3_tag == TAG_W'(gi));
    end
  endgenerate

  // Round-robin search: walk from ptr+1 with wrap, first pending requester wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = ptr_reg;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + TAG_W'(1);
      if (run && !grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A grant is only ever offered to a requester that is valid, so any grant is a handshake
  assign accept = |(req_valid & req_ready);

  // Sign-extend operands so a plain 2W-bit multiply yields the signed product
  assign ext_a = {{DATA_W{s1_a[DATA_W-1]}}, s1_a};
  assign ext_b = {{DATA_W{s1_b[DATA_W-1]}}, s1_b};

`ifdef MUL_ARBITER_SAT_EN
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic [DATA_W:0] prod_top;
  assign prod_top = s2_prod[2*DATA_W-1:DATA_W-1];

  // Clamp when the upper product bits are not a pure sign extension
  always_comb begin
    fmt_res = s2_prod[DATA_W-1:0];
    if (!((prod_top == '0) || (prod_top == '1))) begin
      fmt_res = s2_prod[2*DATA_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  logic unused_prod_hi;
  assign unused_prod_hi = ^s2_prod[2*DATA_W-1:DATA_W];

  // Two's-complement wrap: keep the low DATA_W product bits
  always_comb begin
    fmt_res = s2_prod[DATA_W-1:0];
  end
`endif

  // Round-robin pointer and accepted-operation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg       <= LAST_IDX;
      issue_cnt_reg <= '0;
    end else if (accept) begin
      ptr_reg       <= grant_idx;
      issue_cnt_reg <= issue_cnt_reg + 32'd1;
    end
  end

  // Three-stage multiply pipeline; reset discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      s3_valid     <= 1'b0;
      s1_tag       <= '0;
      s2_tag       <= '0;
      s3_tag       <= '0;
      s1_a         <= '0;
      s1_b         <= '0;
      s2_prod      <= '0;
      res_data_reg <= '0;
    end else begin
      s1_valid <= accept;
      s1_tag   <= grant_idx;
      if (accept) begin
        s1_a <= op_a[grant_idx];
        s1_b <= op_b[grant_idx];
      end
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      if (s1_valid) begin
        s2_prod <= ext_a * ext_b;
      end
      s3_valid <= s2_valid;
      s3_tag   <= s2_tag;
      // Result bus holds its last value between strobes
      if (s2_valid) begin
        res_data_reg <= fmt_res;
      end
    end
  end

  assign res_data  = res_data_reg;
  assign busy      = s1_valid | s2_valid | s3_valid;
  assign issue_cnt = issue_cnt_reg;

endmodule
